// File: rtl/perf_event_counter_if.sv
// Control/status bundle for perf_event_counter: run/clear/snapshot controls, event strobes,
// read select and the counter status outputs.
interface perf_event_counter_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 5
);
  logic               start_i;
  logic               clear_i;
  logic [NUM_EVT-1:0] evt_i;
  logic               snap_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [CNT_W-1:0]   cycle_o;
  logic               running_o;
  logic               done_o;
  logic [NUM_EVT-1:0] ovf_o;

  modport master (
    output start_i, clear_i, evt_i, snap_i, rd_sel_i,
    input  rd_data_o, cycle_o, running_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, clear_i, evt_i, snap_i, rd_sel_i,
    output rd_data_o, cycle_o, running_o, done_o, ovf_o
  );
endinterface

// File: rtl/perf_event_counter.sv
// Saturating per-event counters plus a run-cycle counter with budget auto-stop and a registered
// read port. Define PERF_SNAPSHOT_EN to read from an atomically captured shadow copy instead.
module perf_event_counter #(
  parameter int NUM_EVT   = 4,
  parameter int CNT_W     = 32,
  parameter int CYC_LIMIT = 30,
  parameter int SEL_W     = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  perf_event_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYC_LIMIT - 1);
  localparam logic [SEL_W-1:0] CYC_SEL  = SEL_W'(NUM_EVT);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cycle_reg, cycle_next;
  logic [CNT_W-1:0]   cnt_reg  [NUM_EVT];
  logic [CNT_W-1:0]   cnt_next [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_reg, ovf_next;
  logic [CNT_W-1:0]   rd_data_reg, rd_data_next;
  logic               running_reg, done_reg;
  logic [CNT_W-1:0]   src_cnt  [NUM_EVT];
  logic [CNT_W-1:0]   src_cyc;
  logic               counting;

  assign counting = (state_reg == RUN);

  // Run control and cycle counter; the budget check wins over a same-cycle pause.
  always_comb begin
    state_next = state_reg;
    cycle_next = cycle_reg;
    if (bus.clear_i) begin
      state_next = IDLE;
      cycle_next = '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start_i) state_next = RUN;
        RUN: begin
          if (cycle_reg != CNT_MAX) cycle_next = cycle_reg + CNT_ONE;
          if ((CYC_LIMIT != 0) && (cycle_reg == LIMIT_M1)) state_next = DONE;
          else if (!bus.start_i)                             state_next = IDLE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_chan
      logic hit, sat;
      assign hit          = counting && bus.evt_i[gi];
      assign sat          = (cnt_reg[gi] == CNT_MAX);
      assign cnt_next[gi] = bus.clear_i   ? '0 :
                            (hit && !sat) ? cnt_reg[gi] + CNT_ONE : cnt_reg[gi];
      assign ovf_next[gi] = bus.clear_i ? 1'b0 : (ovf_reg[gi] | (hit & sat));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cycle_reg   <= '0;
      ovf_reg     <= '0;
      rd_data_reg <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) cnt_reg[k] <= '0;
    end else begin
      state_reg   <= state_next;
      cycle_reg   <= cycle_next;
      ovf_reg     <= ovf_next;
      rd_data_reg <= rd_data_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == DONE);
      for (int k = 0; k < NUM_EVT; k++) cnt_reg[k] <= cnt_next[k];
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_cnt_reg [NUM_EVT];
  logic [CNT_W-1:0] shadow_cyc_reg;

  // Shadow captures the post-update values so a snapshot includes the snap cycle itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_cyc_reg <= '0;
      for (int k = 0; k < NUM_EVT; k++) shadow_cnt_reg[k] <= '0;
    end else if (bus.clear_i) begin
      shadow_cyc_reg <= '0;
      for (int k = 0; k < NUM_EVT; k++) shadow_cnt_reg[k] <= '0;
    end else if (bus.snap_i) begin
      shadow_cyc_reg <= cycle_next;
      for (int k = 0; k < NUM_EVT; k++) shadow_cnt_reg[k] <= cnt_next[k];
    end
  end

  assign src_cyc = shadow_cyc_reg;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_src
      assign src_cnt[gi] = shadow_cnt_reg[gi];
    end
  endgenerate
`else
  logic unused_snap;
  assign unused_snap = bus.snap_i;
  assign src_cyc     = cycle_reg;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_src
      assign src_cnt[gi] = cnt_reg[gi];
    end
  endgenerate
`endif

  // Out-of-range selects read as zero.
  always_comb begin
    rd_data_next = '0;
    if (bus.rd_sel_i == CYC_SEL) rd_data_next = src_cyc;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (bus.rd_sel_i == SEL_W'(k)) rd_data_next = src_cnt[k];
    end
  end

  assign bus.rd_data_o = rd_data_reg;
  assign bus.cycle_o   = cycle_reg;
  assign bus.running_o = running_reg;
  assign bus.done_o    = done_reg;
  assign bus.ovf_o     = ovf_reg;

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench for perf_event_counter: a default instance (CNT_W=32, budget 30) and a
// narrow unlimited instance (CNT_W=4) for saturation.
module tb_perf_event_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  perf_event_counter_if #(.NUM_EVT(4), .CNT_W(32), .SEL_W(5)) ifa ();
  perf_event_counter_if #(.NUM_EVT(4), .CNT_W(4),  .SEL_W(5)) ifb ();

  perf_event_counter #(.NUM_EVT(4), .CNT_W(32), .CYC_LIMIT(30), .SEL_W(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa)
  );
  perf_event_counter #(.NUM_EVT(4), .CNT_W(4), .CYC_LIMIT(0), .SEL_W(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.start_i = 0; ifa.clear_i = 0; ifa.evt_i = '0; ifa.snap_i = 0; ifa.rd_sel_i = '0;
    ifb.start_i = 0; ifb.clear_i = 0; ifb.evt_i = '0; ifb.snap_i = 0; ifb.rd_sel_i = '0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_cycle", ifa.cycle_o, 0);
    chk("rst_running", {31'd0, ifa.running_o}, 0);
    chk("rst_done", {31'd0, ifa.done_o}, 0);
    chk("rst_rd_data", ifa.rd_data_o, 0);
    chk("rst_ovf_b", {28'd0, ifb.ovf_o}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Budget run: 30 RUN cycles then DONE
    ifa.start_i = 1; ifa.evt_i = 4'b0001;
    tick();
    chk("t1_running", {31'd0, ifa.running_o}, 1);
    chk("t1_cycle0", ifa.cycle_o, 0);
    repeat (29) tick();
    chk("t1_cycle29", ifa.cycle_o, 29);
    chk("t1_not_done29", {31'd0, ifa.done_o}, 0);
    tick();
    chk("t1_cycle30", ifa.cycle_o, 30);
    chk("t1_done", {31'd0, ifa.done_o}, 1);
    chk("t1_stopped", {31'd0, ifa.running_o}, 0);
    repeat (3) tick();
    chk("t1_cycle_hold", ifa.cycle_o, 30);
    chk("t1_done_hold", {31'd0, ifa.done_o}, 1);
    ifa.rd_sel_i = 5'd0; tick();
    chk("t1_evt0", ifa.rd_data_o, 30);
    ifa.rd_sel_i = 5'd4; tick();
    chk("t1_rd_cycle", ifa.rd_data_o, 30);
    ifa.rd_sel_i = 5'd1; tick();
    chk("t1_evt1", ifa.rd_data_o, 0);
    ifa.rd_sel_i = 5'd7; tick();
    chk("t1_rd_invalid", ifa.rd_data_o, 0);

    ifa.clear_i = 1; ifa.start_i = 0; ifa.evt_i = '0;
    tick();
    chk("clr_done", {31'd0, ifa.done_o}, 0);
    chk("clr_cycle", ifa.cycle_o, 0);
    ifa.clear_i = 0;

    // Pause/resume: 10 run, pause, 4 with start high -> 14
    ifa.start_i = 1; ifa.evt_i = 4'b0100;
    tick();
    repeat (10) tick();
    chk("t2_cycle10", ifa.cycle_o, 10);
    ifa.start_i = 0;
    tick();
    chk("t2_pause_cycle", ifa.cycle_o, 11);
    chk("t2_pause_running", {31'd0, ifa.running_o}, 0);
    repeat (4) tick();
    chk("t2_pause_hold", ifa.cycle_o, 11);
    ifa.start_i = 1;
    repeat (4) tick();
    chk("t2_cycle14", ifa.cycle_o, 14);
    chk("t2_running", {31'd0, ifa.running_o}, 1);
    ifa.start_i = 0;
    tick();
    ifa.evt_i = '0; ifa.rd_sel_i = 5'd2;
    tick();
    chk("t2_evt2", ifa.rd_data_o, 15);

    // Clear beats simultaneous event and start
    ifa.clear_i = 1; ifa.start_i = 1; ifa.evt_i = 4'b0100;
    tick();
    chk("t4_cycle", ifa.cycle_o, 0);
    chk("t4_running", {31'd0, ifa.running_o}, 0);
    chk("t4_ovf", {28'd0, ifa.ovf_o}, 0);
    ifa.clear_i = 0; ifa.start_i = 0; ifa.evt_i = '0;
    tick();
    chk("t4_evt2", ifa.rd_data_o, 0);

    // Saturation on the 4-bit instance
    ifb.start_i = 1; ifb.evt_i = 4'b0010;
    tick();
    repeat (15) tick();
    chk("t3_cycle15", {28'd0, ifb.cycle_o}, 15);
    chk("t3_ovf_before", {28'd0, ifb.ovf_o}, 0);
    tick();
    chk("t3_ovf_set", {28'd0, ifb.ovf_o}, 32'b0010);
    repeat (4) tick();
    chk("t3_ovf_sticky", {28'd0, ifb.ovf_o}, 32'b0010);
    chk("t3_cycle_sat", {28'd0, ifb.cycle_o}, 15);
    chk("t3_running", {31'd0, ifb.running_o}, 1);
    ifb.start_i = 0; ifb.evt_i = '0; ifb.rd_sel_i = 5'd1;
    tick();
    tick();
    chk("t3_evt1", {28'd0, ifb.rd_data_o}, 15);
    ifb.rd_sel_i = 5'd0;
    tick();
    chk("t3_evt0", {28'd0, ifb.rd_data_o}, 0);

    // Snapshot vs live read of the cycle counter
    ifa.rd_sel_i = 5'd4; ifa.start_i = 1;
    tick();
    repeat (6) tick();
    chk("t6_cycle6", ifa.cycle_o, 6);
    ifa.snap_i = 1;
    tick();
    ifa.snap_i = 0;
    repeat (4) tick();
    ifa.start_i = 0;
    tick();
    chk("t6_cycle12", ifa.cycle_o, 12);
    tick();
`ifdef PERF_SNAPSHOT_EN
    chk("t6_rd_shadow", ifa.rd_data_o, 7);
`else
    chk("t6_rd_live", ifa.rd_data_o, 12);
`endif

    // Asynchronous reset mid-run
    ifa.start_i = 1; ifa.evt_i = 4'b0001; ifa.rd_sel_i = 5'd0;
    repeat (3) tick();
    chk("t5_pre_cycle", ifa.cycle_o, 14);
    #2 rst = 1'b1;
    #1;
    chk("t5_cycle", ifa.cycle_o, 0);
    chk("t5_running", {31'd0, ifa.running_o}, 0);
    chk("t5_rd_data", ifa.rd_data_o, 0);
    chk("t5_ovf_b", {28'd0, ifb.ovf_o}, 0);
    chk("t5_cycle_b", {28'd0, ifb.cycle_o}, 0);
    ifa.start_i = 0; ifa.evt_i = '0;
    @(negedge clk) rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
